// File: rtl/m_andn_detect_if.sv
// Bus bundle for m_andn_detect: match/mask inputs, control strobes and detector outputs.
interface m_andn_detect_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] MASK;
  logic             EN;
  logic             CLR;
  logic             B;
  logic             B_RISE;
  logic             STICKY;

  modport master (output A, MASK, EN, CLR, input B, B_RISE, STICKY);
  modport slave  (input A, MASK, EN, CLR, output B, B_RISE, STICKY);
endinterface

// File: rtl/m_andn_detect.sv
// Masked wide-AND detector: 4-input NAND/NOR reduction tree (optionally registered per level)
// followed by a HOLD-cycle qualifier. Define ANDN_DETECT_STICKY_EN to build the STICKY flag.
module m_andn_detect #(
  parameter int WIDTH = 11,
  parameter int PIPE  = 1,
  parameter int HOLD  = 1
) (
  input logic            MasterClock,
  input logic            RESETL,
  m_andn_detect_if.slave bus
);

  function automatic int f_levels(input int w);
    int l;
    l = 1;
    while ((4 ** l) < w) l++;
    return l;
  endfunction

  localparam int LEVELS = f_levels(WIDTH);
  localparam int NTERM  = 4 ** LEVELS;
  localparam int CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  // Unused tree leaves are padded true so they never block the AND.
  logic [NTERM-1:0] term;
  always_comb begin
    term            = '1;
    term[WIDTH-1:0] = bus.A | ~bus.MASK;
  end

  // Levels alternate NAND/NOR; each level output is re-expressed in true polarity so a
  // reset-cleared pipeline register reads as "not matched" rather than a phantom match.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = 4 ** (LEVELS - l);
    localparam int NO = NI / 4;
    logic [NI-1:0] in_t;
    logic [NO-1:0] grp_d;
    logic [NO-1:0] out_t;

    if (l == 0) begin : g_in0
      assign in_t = term;
    end else begin : g_inn
      assign in_t = g_lvl[l-1].out_t;
    end

    always_comb begin
      grp_d = '0;
      for (int g = 0; g < NO; g++) begin
        if (l % 2 == 0) grp_d[g] = ~(~&in_t[4*g +: 4]);
        else            grp_d[g] = ~|(~in_t[4*g +: 4]);
      end
    end

    if (PIPE != 0) begin : g_reg
      logic [NO-1:0] grp_q;
      always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) grp_q <= '0;
        else         grp_q <= grp_d;
      end
      assign out_t = grp_q;
    end else begin : g_comb
      assign out_t = grp_d;
    end
  end

  logic raw;
  assign raw = g_lvl[LEVELS-1].out_t[0];

  logic [CW-1:0] cnt_d, cnt_q;
  logic          b_d, b_q;
  logic          rise_d, rise_q;

  always_comb begin
    cnt_d = '0;
    if (bus.EN && raw) cnt_d = (cnt_q == HOLD_C) ? HOLD_C : cnt_q + 1'b1;
    b_d    = (cnt_d == HOLD_C);
    rise_d = b_d && !b_q;
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      cnt_q  <= '0;
      b_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      b_q    <= b_d;
      rise_q <= rise_d;
    end
  end

  assign bus.B      = b_q;
  assign bus.B_RISE = rise_q;

`ifdef ANDN_DETECT_STICKY_EN
  logic sticky_d, sticky_q;

  // A rise beats a coincident clear; clears are ignored while the detector is disabled.
  always_comb begin
    sticky_d = sticky_q;
    if (rise_q)                  sticky_d = 1'b1;
    else if (bus.CLR && bus.EN)  sticky_d = 1'b0;
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) sticky_q <= 1'b0;
    else         sticky_q <= sticky_d;
  end

  assign bus.STICKY = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = bus.CLR;
  assign bus.STICKY = 1'b0;
`endif

endmodule

// File: tb/tb_m_andn_detect.sv
// Directed bench for m_andn_detect: three parameterisations driven side by side.
module tb_m_andn_detect;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef ANDN_DETECT_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  m_andn_detect_if #(.WIDTH(11)) i0 ();
  m_andn_detect_if #(.WIDTH(11)) i1 ();
  m_andn_detect_if #(.WIDTH(64)) i2 ();

  m_andn_detect #(.WIDTH(11), .PIPE(0), .HOLD(1)) u0 (.MasterClock(clk), .RESETL(rst_n), .bus(i0));
  m_andn_detect #(.WIDTH(11), .PIPE(1), .HOLD(3)) u1 (.MasterClock(clk), .RESETL(rst_n), .bus(i1));
  m_andn_detect #(.WIDTH(64), .PIPE(1), .HOLD(1)) u2 (.MasterClock(clk), .RESETL(rst_n), .bus(i2));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, " u0.B"},      i0.B,      0);
    check({tag, " u0.B_RISE"}, i0.B_RISE, 0);
    check({tag, " u0.STICKY"}, i0.STICKY, 0);
    check({tag, " u1.B"},      i1.B,      0);
    check({tag, " u1.B_RISE"}, i1.B_RISE, 0);
    check({tag, " u1.STICKY"}, i1.STICKY, 0);
    check({tag, " u2.B"},      i2.B,      0);
    check({tag, " u2.B_RISE"}, i2.B_RISE, 0);
    check({tag, " u2.STICKY"}, i2.STICKY, 0);
  endtask

  // Ticks 1..6: rise after reset release; ticks 7..12: one-cycle glitch and recovery.
  bit p1_b0 [6] = '{1, 1, 1, 1, 1, 1};
  bit p1_r0 [6] = '{1, 0, 0, 0, 0, 0};
  bit p1_b1 [6] = '{0, 0, 0, 0, 1, 1};
  bit p1_r1 [6] = '{0, 0, 0, 0, 1, 0};
  bit p1_b2 [6] = '{0, 0, 0, 1, 1, 1};
  bit p1_r2 [6] = '{0, 0, 0, 1, 0, 0};
  bit p2_b0 [6] = '{0, 1, 1, 1, 1, 1};
  bit p2_r0 [6] = '{0, 1, 0, 0, 0, 0};
  bit p2_b1 [6] = '{1, 1, 0, 0, 0, 1};
  bit p2_r1 [6] = '{0, 0, 0, 0, 0, 1};
  bit p2_b2 [6] = '{1, 1, 1, 0, 1, 1};
  bit p2_r2 [6] = '{0, 0, 0, 0, 1, 0};

  logic [10:0] p3_a [5] = '{11'h000, 11'h00F, 11'h007, 11'h000, 11'h3FF};
  logic [10:0] p3_m [5] = '{11'h7FF, 11'h00F, 11'h00F, 11'h000, 11'h400};
  bit          p3_b [5] = '{0, 1, 0, 1, 0};

  // Ticks 18..31 on u1: fall, requalify with an EN drop at count 2, STICKY set/clear.
  bit p4_b [14] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  bit p4_r [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  bit p4_s [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0};

  bit p5_b0 [5] = '{1, 1, 1, 1, 1};
  bit p5_b1 [5] = '{0, 0, 0, 0, 1};
  bit p5_b2 [5] = '{0, 0, 0, 1, 1};

  initial begin
    rst_n = 1'b1;
    i0.A = '0; i0.MASK = '1; i0.EN = 1'b1; i0.CLR = 1'b0;
    i1.A = '0; i1.MASK = '1; i1.EN = 1'b1; i1.CLR = 1'b0;
    i2.A = '0; i2.MASK = '1; i2.EN = 1'b1; i2.CLR = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");

    tick();
    i0.A = '1; i1.A = '1; i2.A = '1;
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("t%0d u0.B", t + 1),      i0.B,      p1_b0[t]);
      check($sformatf("t%0d u0.B_RISE", t + 1), i0.B_RISE, p1_r0[t]);
      check($sformatf("t%0d u1.B", t + 1),      i1.B,      p1_b1[t]);
      check($sformatf("t%0d u1.B_RISE", t + 1), i1.B_RISE, p1_r1[t]);
      check($sformatf("t%0d u2.B", t + 1),      i2.B,      p1_b2[t]);
      check($sformatf("t%0d u2.B_RISE", t + 1), i2.B_RISE, p1_r2[t]);
    end
    check("t6 u0.STICKY", i0.STICKY, STK);
    check("t6 u1.STICKY", i1.STICKY, STK);
    check("t6 u2.STICKY", i2.STICKY, STK);

    i0.A = 11'h7FE; i1.A = 11'h7FE; i2.A = {1'b0, {63{1'b1}}};
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t == 0) begin
        i0.A = '1; i1.A = '1; i2.A = '1;
      end
      check($sformatf("t%0d u0.B", t + 7),      i0.B,      p2_b0[t]);
      check($sformatf("t%0d u0.B_RISE", t + 7), i0.B_RISE, p2_r0[t]);
      check($sformatf("t%0d u1.B", t + 7),      i1.B,      p2_b1[t]);
      check($sformatf("t%0d u1.B_RISE", t + 7), i1.B_RISE, p2_r1[t]);
      check($sformatf("t%0d u2.B", t + 7),      i2.B,      p2_b2[t]);
      check($sformatf("t%0d u2.B_RISE", t + 7), i2.B_RISE, p2_r2[t]);
    end

    for (int v = 0; v < 5; v++) begin
      i0.A = p3_a[v];
      i0.MASK = p3_m[v];
      tick();
      check($sformatf("mask%0d u0.B", v),      i0.B,      p3_b[v]);
      check($sformatf("mask%0d u0.B_RISE", v), i0.B_RISE, p3_b[v]);
    end
    check("t17 u1.B", i1.B, 1);
    check("t17 u2.B", i2.B, 1);

    i0.A = '1; i0.MASK = '1;
    i1.A = '0;
    for (int t = 0; t < 14; t++) begin
      tick();
      check($sformatf("t%0d u1.B", t + 18),      i1.B,      p4_b[t]);
      check($sformatf("t%0d u1.B_RISE", t + 18), i1.B_RISE, p4_r[t]);
      check($sformatf("t%0d u1.STICKY", t + 18), i1.STICKY, p4_s[t] & STK);
      case (t + 18)
        21: i1.A = '1;
        25: begin i1.EN = 1'b0; i1.CLR = 1'b1; end
        26: begin i1.EN = 1'b1; i1.CLR = 1'b1; end
        27: i1.CLR = 1'b0;
        29: i1.CLR = 1'b1;
        31: i1.CLR = 1'b0;
        default: ;
      endcase
    end
    check("t31 u0.B", i0.B, 1);
    check("t31 u0.STICKY", i0.STICKY, STK);

    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    #1 rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("t%0d u0.B", t + 32), i0.B, p5_b0[t]);
      check($sformatf("t%0d u1.B", t + 32), i1.B, p5_b1[t]);
      check($sformatf("t%0d u2.B", t + 32), i2.B, p5_b2[t]);
    end
    check("t36 u1.B_RISE", i1.B_RISE, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/m_andn_detect.md
M_ANDN_DETECT -- requirements
Module: m_andn_detect

Interface
REQ-001 Parameter WIDTH, default 11: number of match inputs, legal range 1..64.
REQ-002 Parameter PIPE, default 1: 0 = combinational reduction tree, 1 = every tree level registered.
REQ-003 Parameter HOLD, default 1: consecutive true cycles required before B asserts, legal range 1..255.
REQ-004 MasterClock  input  1  sole clock; all state changes on its rising edge.
REQ-005 RESETL  input  1  asynchronous, active-low reset.
REQ-006 A  input  WIDTH  match inputs; A[0] corresponds to A_1 of the fixed-width AND gates.
REQ-007 MASK  input  WIDTH  1 = bit participates; 0 = bit forced true.
REQ-008 EN  input  1  detector enable.
REQ-009 CLR  input  1  clears STICKY.
REQ-010 B  output  1  qualified, registered AND result.
REQ-011 B_RISE  output  1  one-cycle pulse on each 0->1 transition of B.
REQ-012 STICKY  output  1  latched "B has risen" flag.

Function
REQ-013 Per-bit term SHALL be t[i] = A[i] OR NOT MASK[i]; RAW SHALL be the AND of all t[i].
- MASK all zeros gives RAW = 1.
REQ-014 Reduction SHALL be a tree of 4-input NAND/NOR groups.
- LEVELS = max(1, ceil(log4(WIDTH))).
- WIDTH=11 gives LEVELS=2; WIDTH=64 gives LEVELS=3.
REQ-015 With PIPE=1, RAW SHALL reach the qualifier exactly LEVELS cycles after A/MASK are sampled; with PIPE=0 it SHALL reach it in the same cycle.
REQ-016 The qualifier counter SHALL be ceil(log2(HOLD+1)) bits wide.
- Increments while RAW=1 and EN=1, saturating at HOLD.
- Loads 0 on any cycle with RAW=0.
REQ-017 B SHALL be registered high on the edge where the counter reaches HOLD, and SHALL stay high while it remains at HOLD.
- End-to-end latency from A all-true to B=1 is PIPE*LEVELS + HOLD cycles.
REQ-018 B SHALL drop on the first edge on which the delayed RAW is 0.
- Fall latency is PIPE*LEVELS + 1 cycles.
REQ-019 EN=0 SHALL clear the counter, B and B_RISE on the next edge.
- Pipeline registers keep advancing while EN=0.
REQ-020 B_RISE SHALL be 1 for exactly the cycle in which B first reads 1 after reading 0, and 0 otherwise.
REQ-021 A single-cycle RAW=0 glitch SHALL restart qualification from count 0.

Reset
REQ-022 RESETL=0 SHALL immediately, without a clock, force all of the following to 0:
- all pipeline registers, the counter, B, B_RISE and STICKY.
REQ-023 After RESETL rises, the first possible B=1 SHALL come no earlier than PIPE*LEVELS + HOLD edges later.
REQ-024 Reset asserted mid-qualification SHALL discard the partial count.

Configuration
REQ-025 Macro ANDN_DETECT_STICKY_EN, when defined, SHALL compile in the STICKY register.
- STICKY sets on B_RISE=1 and clears on CLR=1.
- B_RISE and CLR in the same cycle: set wins.
- STICKY holds its value while EN=0.
REQ-026 Without ANDN_DETECT_STICKY_EN, STICKY SHALL be constant 0, CLR SHALL be ignored, and no STICKY register SHALL exist.

Verification
REQ-027 WIDTH=11, PIPE=0, HOLD=1, MASK=all ones; A=0x7FF at edge k -> B=1 and B_RISE=1 after edge k+1; B_RISE=0 after edge k+2.
- This case matches the legacy 11-input AND behaviour plus one register.
REQ-028 WIDTH=11, PIPE=1, HOLD=3, MASK=0x7FF; A=0x7FF held -> B rises 5 cycles after first sample.
- A=0x7FE for one cycle -> B falls 3 cycles later and re-rises 5 cycles after A returns to 0x7FF.
REQ-029 WIDTH=11, MASK=0x00F, A=0x00F -> B=1; MASK=0x000 with A=0x000 -> B=1 (vacuous-true case).
REQ-030 Qualification in progress at count 2 of HOLD=3, then EN=0 for 1 cycle -> counter=0, B stays 0, full HOLD required again.
- Separately, RESETL pulsed low mid-cycle -> B, B_RISE and STICKY read 0 before the next edge.
REQ-031 With ANDN_DETECT_STICKY_EN, B_RISE and CLR coincident -> STICKY=1; CLR alone -> STICKY=0.
- Without the macro, STICKY=0 throughout the same stimulus.
REQ-032 WIDTH=64, PIPE=1, HOLD=1, A=all ones -> B rises 4 cycles after sampling (LEVELS=3).
